// File: rtl/sram_resp_pkg.sv
// Shared types, boot image and lane helpers for the SRAM responder.
// Included by every file of the responder slice.
package sram_resp_pkg;

    typedef enum logic [1:0] {INIT, IDLE, READ} state_t;

    localparam int IMG_WORDS = 16;

    localparam logic [15:0] INIT_IMAGE [IMG_WORDS] = '{
        16'h5020, 16'h1021, 16'h0FFE, 16'h0000,
        16'h0000, 16'h0000, 16'h0000, 16'h0000,
        16'h0000, 16'h0000, 16'h0000, 16'h0000,
        16'h0000, 16'h0000, 16'h0000, 16'h0000
    };

    function automatic logic [15:0] image_word(input int unsigned i);
        logic [3:0] sel;
        sel = i[3:0];
        image_word = (i < IMG_WORDS) ? INIT_IMAGE[sel] : 16'h0000;
    endfunction

    // Active-low lane enables to a 16-bit keep mask.
    function automatic logic [15:0] lane_mask(input logic ub, input logic lb);
        lane_mask = {{8{~ub}}, {8{~lb}}};
    endfunction

endpackage

// File: rtl/sram_byte_ram.sv
// DEPTH x 16 storage: two byte write-enables, one synchronous read port.
// Read returns pre-write contents when addresses collide on one edge.
module sram_byte_ram
    import sram_resp_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we_hi,
    input  logic          we_lo,
    input  logic [AW-1:0] waddr,
    input  logic [15:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [15:0]   rdata
);

    logic [7:0] mem_hi [DEPTH];
    logic [7:0] mem_lo [DEPTH];

    always_ff @(posedge clk) begin
        if (we_lo) mem_lo[waddr] <= wdata[7:0];
        if (we_hi) mem_hi[waddr] <= wdata[15:8];
        rdata <= {mem_hi[raddr], mem_lo[raddr]};
    end

endmodule

// File: rtl/sram_responder.sv
// Async-SRAM-style bus responder: self-loads a boot image, then serves byte-laned access.
// Define SRAM_WRITE_PROTECT_EN to lock the low PROTECT_WORDS words after load.
module sram_responder
    import sram_resp_pkg::*;
#(
    parameter int DEPTH         = 256,
    parameter int READ_LAT      = 1,
    parameter int INIT_WORDS    = 16,
    parameter int PROTECT_WORDS = 8
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        CE,
    input  logic        UB,
    input  logic        LB,
    input  logic        OE,
    input  logic        WE,
    input  logic [19:0] ADDR,
    input  logic [15:0] Data_in,
    output logic [15:0] Data_out,
    output logic        Data_drive,
    output logic        Init_busy
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);
    localparam logic [1:0]    LAST_CNT = 2'(READ_LAT - 1);
`ifdef SRAM_WRITE_PROTECT_EN
    localparam bit PROT_EN = 1'b1;
`else
    localparam bit PROT_EN = 1'b0;
`endif

    state_t        state, state_n;
    logic [AW-1:0] ptr, ptr_n;
    logic [1:0]    cnt, cnt_n;
    logic [21:0]   key, key_n, key_cur;
    logic [15:0]   dout_n, rdata, rd_word, wdata;
    logic          drive_n, wr, rd, oor, prot;
    logic          we_hi, we_lo;
    logic [AW-1:0] idx, waddr;

    assign idx     = ADDR[AW-1:0];
    assign wr      = ~CE & ~WE;
    assign rd      = ~CE & WE & ~OE;
    assign oor     = 32'(ADDR) >= 32'(DEPTH);
    assign prot    = PROT_EN && (32'(idx) < 32'(PROTECT_WORDS));
    assign key_cur = {ADDR, UB, LB};
    assign rd_word = oor ? 16'h0000 : (rdata & lane_mask(UB, LB));

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state      <= INIT;
            ptr        <= '0;
            cnt        <= '0;
            key        <= '0;
            Data_out   <= '0;
            Data_drive <= 1'b0;
        end else begin
            state      <= state_n;
            ptr        <= ptr_n;
            cnt        <= cnt_n;
            key        <= key_n;
            Data_out   <= dout_n;
            Data_drive <= drive_n;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            INIT: state_n = (ptr == LAST_IDX) ? IDLE : INIT;
            IDLE: state_n = (!wr && rd) ? READ : IDLE;
            READ: state_n = (!wr && rd) ? READ : IDLE;
            default: state_n = INIT;
        endcase
    end

    // A changed address or lane set during a read restarts the latency count.
    always_comb begin
        ptr_n     = ptr;
        cnt_n     = cnt;
        key_n     = key;
        dout_n    = Data_out;
        drive_n   = 1'b0;
        we_hi     = 1'b0;
        we_lo     = 1'b0;
        waddr     = idx;
        wdata     = Data_in;
        Init_busy = (state == INIT);
        unique case (state)
            INIT: begin
                we_hi = ~Reset;
                we_lo = ~Reset;
                waddr = ptr;
                wdata = (32'(ptr) < 32'(INIT_WORDS)) ? image_word(32'(ptr)) : 16'h0000;
                ptr_n = ptr + AW'(1);
            end
            IDLE, READ: begin
                if (wr) begin
                    if (!oor && !prot && !Reset) begin
                        we_lo = ~LB;
                        we_hi = ~UB;
                    end
                end else if (rd) begin
                    if (state == IDLE || key_cur != key) begin
                        key_n = key_cur;
                        cnt_n = '0;
                    end else if (Data_drive) begin
                        drive_n = 1'b1;
                    end else if (cnt == LAST_CNT) begin
                        dout_n  = rd_word;
                        drive_n = 1'b1;
                    end else begin
                        cnt_n = cnt + 2'd1;
                    end
                end
            end
            default: ;
        endcase
    end

    sram_byte_ram #(
        .DEPTH(DEPTH),
        .AW   (AW)
    ) u_ram (
        .clk  (Clk),
        .we_hi(we_hi),
        .we_lo(we_lo),
        .waddr(waddr),
        .wdata(wdata),
        .raddr(idx),
        .rdata(rdata)
    );

endmodule

// File: tb/tb_sram_responder.sv
// Directed bench for sram_responder: init timing, reads, byte lanes,
// priority, out-of-range, back-to-back and reset during load.
module tb_sram_responder;

    logic        Clk = 1'b0;
    logic        Reset, CE, UB, LB, OE, WE;
    logic [19:0] ADDR;
    logic [15:0] Data_in, Data_out;
    logic        Data_drive, Init_busy;

    int n_run  = 0;
    int n_fail = 0;

    always #5 Clk = ~Clk;

    sram_responder dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .CE        (CE),
        .UB        (UB),
        .LB        (LB),
        .OE        (OE),
        .WE        (WE),
        .ADDR      (ADDR),
        .Data_in   (Data_in),
        .Data_out  (Data_out),
        .Data_drive(Data_drive),
        .Init_busy (Init_busy)
    );

    task automatic bus_write(input logic [19:0] a, input logic [15:0] d,
                             input logic ub, input logic lb);
        @(negedge Clk);
        CE = 0; WE = 0; OE = 1; ADDR = a; Data_in = d; UB = ub; LB = lb;
    endtask

    task automatic bus_read(input logic [19:0] a, input logic ub, input logic lb,
                            output logic [15:0] d, output logic gap,
                            output logic drv, output logic drop);
        @(negedge Clk);
        CE = 0; WE = 1; OE = 0; ADDR = a; UB = ub; LB = lb;
        @(negedge Clk);
        gap = Data_drive;
        @(negedge Clk);
        d = Data_out; drv = Data_drive;
        CE = 1; OE = 1;
        @(negedge Clk);
        drop = Data_drive;
    endtask

    task automatic count_init(output int n, output logic drv);
        n = 0; drv = 0;
        for (int i = 0; i < 1000; i++) begin
            if (!Init_busy) break;
            n++;
            if (Data_drive) drv = 1;
            @(negedge Clk);
        end
    endtask

    task automatic test_reset();
        int n; logic drv;
        Reset = 1; CE = 1; WE = 1; OE = 1; UB = 0; LB = 0;
        ADDR = '0; Data_in = '0;
        @(negedge Clk);
        n_run++;
        if (Init_busy !== 1'b1) begin
            n_fail++; $display("FAIL reset_busy: got %b want 1", Init_busy);
        end
        n_run++;
        if (Data_drive !== 1'b0) begin
            n_fail++; $display("FAIL reset_drive: got %b want 0", Data_drive);
        end
        n_run++;
        if (Data_out !== 16'h0000) begin
            n_fail++; $display("FAIL reset_dout: got %h want 0000", Data_out);
        end
        Reset = 0;
        count_init(n, drv);
        n_run++;
        if (n != 256) begin
            n_fail++; $display("FAIL init_cycles: got %0d want 256", n);
        end
        n_run++;
        if (drv !== 1'b0) begin
            n_fail++; $display("FAIL init_drive: got %b want 0", drv);
        end
    endtask

    task automatic test_init_reads();
        logic [15:0] d; logic gap, drv, drop;
        bus_read(20'h0, 0, 0, d, gap, drv, drop);
        n_run++;
        if (gap !== 1'b0) begin
            n_fail++; $display("FAIL rd0_gap: got %b want 0", gap);
        end
        n_run++;
        if (d !== 16'h5020 || drv !== 1'b1) begin
            n_fail++; $display("FAIL rd0: got %h/%b want 5020/1", d, drv);
        end
        n_run++;
        if (drop !== 1'b0) begin
            n_fail++; $display("FAIL rd0_drop: got %b want 0", drop);
        end
        @(negedge Clk);
        CE = 0; WE = 1; OE = 0; ADDR = 20'h0; UB = 0; LB = 0;
        @(negedge Clk);
        @(negedge Clk);
        n_run++;
        if (Data_out !== 16'h5020 || Data_drive !== 1'b1) begin
            n_fail++; $display("FAIL hold0: got %h/%b want 5020/1", Data_out, Data_drive);
        end
        ADDR = 20'h1;
        @(negedge Clk);
        n_run++;
        if (Data_drive !== 1'b0) begin
            n_fail++; $display("FAIL recount_gap: got %b want 0", Data_drive);
        end
        @(negedge Clk);
        n_run++;
        if (Data_out !== 16'h1021 || Data_drive !== 1'b1) begin
            n_fail++; $display("FAIL rd1: got %h/%b want 1021/1", Data_out, Data_drive);
        end
        @(negedge Clk);
        n_run++;
        if (Data_out !== 16'h1021 || Data_drive !== 1'b1) begin
            n_fail++; $display("FAIL rd1_hold: got %h/%b want 1021/1", Data_out, Data_drive);
        end
        CE = 1; OE = 1;
        bus_read(20'h2, 0, 0, d, gap, drv, drop);
        n_run++;
        if (d !== 16'h0FFE) begin
            n_fail++; $display("FAIL rd2: got %h want 0FFE", d);
        end
        bus_read(20'h10, 0, 0, d, gap, drv, drop);
        n_run++;
        if (d !== 16'h0000) begin
            n_fail++; $display("FAIL rd_cleared: got %h want 0000", d);
        end
        bus_read(20'h0, 1, 0, d, gap, drv, drop);
        n_run++;
        if (d !== 16'h0020) begin
            n_fail++; $display("FAIL rd_lo_lane: got %h want 0020", d);
        end
        bus_read(20'h1, 0, 1, d, gap, drv, drop);
        n_run++;
        if (d !== 16'h1000) begin
            n_fail++; $display("FAIL rd_hi_lane: got %h want 1000", d);
        end
    endtask

    task automatic test_byte_lanes();
        logic [15:0] d; logic gap, drv, drop;
        bus_write(20'h10, 16'hABCD, 1, 0);
        bus_read(20'h10, 0, 0, d, gap, drv, drop);
        n_run++;
        if (d !== 16'h00CD) begin
            n_fail++; $display("FAIL wr_lo: got %h want 00CD", d);
        end
        bus_write(20'h10, 16'h1234, 0, 1);
        bus_read(20'h10, 0, 0, d, gap, drv, drop);
        n_run++;
        if (d !== 16'h12CD) begin
            n_fail++; $display("FAIL wr_hi: got %h want 12CD", d);
        end
        bus_write(20'h10, 16'hFFFF, 1, 1);
        bus_read(20'h10, 0, 0, d, gap, drv, drop);
        n_run++;
        if (d !== 16'h12CD) begin
            n_fail++; $display("FAIL wr_no_lane: got %h want 12CD", d);
        end
    endtask

    task automatic test_we_oe_priority();
        logic [15:0] d; logic gap, drv, drop;
        @(negedge Clk);
        CE = 0; WE = 0; OE = 0; ADDR = 20'h5; Data_in = 16'h7777; UB = 0; LB = 0;
        @(negedge Clk);
        n_run++;
        if (Data_drive !== 1'b0) begin
            n_fail++; $display("FAIL prio_drive: got %b want 0", Data_drive);
        end
        CE = 1; WE = 1; OE = 1;
        bus_read(20'h5, 0, 0, d, gap, drv, drop);
        n_run++;
        if (d !== 16'h7777) begin
            n_fail++; $display("FAIL prio_data: got %h want 7777", d);
        end
    endtask

    task automatic test_out_of_range();
        logic [15:0] d; logic gap, drv, drop;
        bus_read(20'h00400, 0, 0, d, gap, drv, drop);
        n_run++;
        if (d !== 16'h0000 || drv !== 1'b1) begin
            n_fail++; $display("FAIL oor_read: got %h/%b want 0000/1", d, drv);
        end
        bus_write(20'h00400, 16'hFFFF, 0, 0);
        bus_read(20'h0, 0, 0, d, gap, drv, drop);
        n_run++;
        if (d !== 16'h5020) begin
            n_fail++; $display("FAIL oor_alias: got %h want 5020", d);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] d; logic gap, drv, drop;
        bus_write(20'h20, 16'h5A5A, 0, 0);
        bus_read(20'h20, 0, 0, d, gap, drv, drop);
        n_run++;
        if (d !== 16'h5A5A) begin
            n_fail++; $display("FAIL raw: got %h want 5A5A", d);
        end
        bus_write(20'h21, 16'hC3C3, 0, 0);
        bus_write(20'h21, 16'h1100, 0, 1);
        bus_read(20'h21, 0, 0, d, gap, drv, drop);
        n_run++;
        if (d !== 16'h11C3) begin
            n_fail++; $display("FAIL ww_merge: got %h want 11C3", d);
        end
    endtask

    task automatic test_write_protect();
        logic [15:0] d, want; logic gap, drv, drop;
`ifdef SRAM_WRITE_PROTECT_EN
        want = 16'h0FFE;
`else
        want = 16'hDEAD;
`endif
        bus_write(20'h2, 16'hDEAD, 0, 0);
        bus_read(20'h2, 0, 0, d, gap, drv, drop);
        n_run++;
        if (d !== want) begin
            n_fail++; $display("FAIL protect_lo: got %h want %h", d, want);
        end
        bus_write(20'h8, 16'hBEEF, 0, 0);
        bus_read(20'h8, 0, 0, d, gap, drv, drop);
        n_run++;
        if (d !== 16'hBEEF) begin
            n_fail++; $display("FAIL protect_edge: got %h want BEEF", d);
        end
    endtask

    task automatic test_reset_mid_init();
        int n; logic drv;
        logic [15:0] d; logic gap, dv, drop;
        @(negedge Clk);
        Reset = 1;
        @(negedge Clk);
        Reset = 0;
        repeat (100) @(negedge Clk);
        Reset = 1;
        @(negedge Clk);
        Reset = 0;
        count_init(n, drv);
        n_run++;
        if (n != 256) begin
            n_fail++; $display("FAIL restart_cycles: got %0d want 256", n);
        end
        bus_read(20'h10, 0, 0, d, gap, dv, drop);
        n_run++;
        if (d !== 16'h0000) begin
            n_fail++; $display("FAIL reload_10: got %h want 0000", d);
        end
        bus_read(20'h2, 0, 0, d, gap, dv, drop);
        n_run++;
        if (d !== 16'h0FFE) begin
            n_fail++; $display("FAIL reload_2: got %h want 0FFE", d);
        end
    endtask

    initial begin
        test_reset();
        test_init_reads();
        test_byte_lanes();
        test_we_oe_priority();
        test_out_of_range();
        test_back_to_back();
        test_write_protect();
        test_reset_mid_init();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
